// File: rtl/write_address_controller_if.sv
// Write-address controller bus.
// Carries the capture controls (arm, sample_valid, trigger) from the sampling side
// and the controller's buffer-write and status outputs back to it.
//   master : drives arm/sample_valid/trigger, observes controller outputs
//   slave  : the controller itself
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

interface write_address_controller_if #(
  parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH
);
  logic                  arm;
  logic                  sample_valid;
  logic                  trigger;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] trigger_addr;
  logic                  triggered;
  logic                  wrapped;
  logic                  capture_done;

  modport master (
    output arm, sample_valid, trigger,
    input  write_enable, waddr, trigger_addr, triggered, wrapped, capture_done
  );

  modport slave (
    input  arm, sample_valid, trigger,
    output write_enable, waddr, trigger_addr, triggered, wrapped, capture_done
  );
endinterface

// File: rtl/write_address_controller.sv
// Write-address controller for a circular capture buffer.
// Once armed, every valid sample is written at waddr and the pointer advances
// modulo the buffer depth. A qualified trigger records its own address, then
// POST_TRIGGER_COUNT further samples are written before the buffer freezes.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : arm/sample_valid/trigger in; write_enable (combinational),
//                  waddr, trigger_addr, triggered, wrapped, capture_done out (registered)
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module write_address_controller #(
  parameter int unsigned ADDR_WIDTH         = `ADDR_WIDTH,
  parameter int unsigned POST_TRIGGER_COUNT = 8
) (
  input logic                        clk,
  input logic                        reset,
  write_address_controller_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StPost, StDone} state_e;

  localparam logic [ADDR_WIDTH-1:0] PostCount = ADDR_WIDTH'(POST_TRIGGER_COUNT);
  localparam logic [ADDR_WIDTH-1:0] AddrMax   = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [ADDR_WIDTH-1:0] trigger_addr_q;
  logic [ADDR_WIDTH-1:0] post_cnt_q;
  logic                  triggered_q;
  logic                  wrapped_q;
  logic                  capture_done_q;

  logic [ADDR_WIDTH-1:0] waddr_inc;
  logic [ADDR_WIDTH-1:0] post_cnt_inc;
  logic                  at_top;

  assign waddr_inc    = waddr_q + ADDR_WIDTH'(1);
  assign post_cnt_inc = post_cnt_q + ADDR_WIDTH'(1);
  assign at_top       = (waddr_q == AddrMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      waddr_q        <= '0;
      trigger_addr_q <= '0;
      post_cnt_q     <= '0;
      triggered_q    <= 1'b0;
      wrapped_q      <= 1'b0;
      capture_done_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.arm) begin
            state_q        <= StArmed;
            waddr_q        <= '0;
            trigger_addr_q <= '0;
            post_cnt_q     <= '0;
            triggered_q    <= 1'b0;
            wrapped_q      <= 1'b0;
            capture_done_q <= 1'b0;
          end
        end
        StArmed: begin
          if (bus.sample_valid) begin
            if (bus.trigger) begin
              triggered_q    <= 1'b1;
              trigger_addr_q <= waddr_q;
              if (PostCount != '0) begin
                waddr_q    <= waddr_inc;
                wrapped_q  <= wrapped_q | at_top;
                post_cnt_q <= '0;
                state_q    <= StPost;
              end else begin
                // No post-trigger samples: freeze on the trigger sample itself.
                capture_done_q <= 1'b1;
                state_q        <= StDone;
              end
            end else begin
              waddr_q   <= waddr_inc;
              wrapped_q <= wrapped_q | at_top;
            end
          end
        end
        StPost: begin
          if (bus.sample_valid) begin
            post_cnt_q <= post_cnt_inc;
            if (post_cnt_inc == PostCount) begin
              // Final write: leave waddr on the last written sample.
              capture_done_q <= 1'b1;
              state_q        <= StDone;
            end else begin
              waddr_q   <= waddr_inc;
              wrapped_q <= wrapped_q | at_top;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.write_enable = bus.sample_valid & ((state_q == StArmed) | (state_q == StPost));
  assign bus.waddr        = waddr_q;
  assign bus.trigger_addr = trigger_addr_q;
  assign bus.triggered    = triggered_q;
  assign bus.wrapped      = wrapped_q;
  assign bus.capture_done = capture_done_q;

endmodule

// File: tb/tb_write_address_controller.sv
module tb_write_address_controller;
  localparam int Depth = 16;
  localparam int MIdle = 0, MArmed = 1, MPost = 2, MDone = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arm = 1'b0, sample_valid = 1'b0, trigger = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Index 0: POST_TRIGGER_COUNT=3, index 1: POST_TRIGGER_COUNT=0.
  write_address_controller_if #(.ADDR_WIDTH(4)) bus3 ();
  write_address_controller_if #(.ADDR_WIDTH(4)) bus0 ();
  assign bus3.arm = arm;
  assign bus3.sample_valid = sample_valid;
  assign bus3.trigger = trigger;
  assign bus0.arm = arm;
  assign bus0.sample_valid = sample_valid;
  assign bus0.trigger = trigger;

  write_address_controller #(.ADDR_WIDTH(4), .POST_TRIGGER_COUNT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3));
  write_address_controller #(.ADDR_WIDTH(4), .POST_TRIGGER_COUNT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  // Reference model: unbounded write count; address and wrap derived arithmetically.
  int ptc[2] = '{3, 0};
  int m_mode[2], m_pos[2], m_trig_pos[2], m_post[2];
  bit m_trig[2];

  // Observations: *_pre sampled before the edge, the rest after it.
  logic       we_pre[2], we_post[2], tr_o[2], wr_o[2], dn_o[2];
  logic [3:0] wa_pre[2], wa_o[2], ta_o[2];
  bit         exp_we_pre[2];
  int         exp_wa_pre[2];

  task automatic model_update(input bit r, input bit a, input bit v, input bit t);
    for (int k = 0; k < 2; k++) begin
      if (r || ((m_mode[k] == MIdle || m_mode[k] == MDone) && a)) begin
        m_mode[k] = r ? MIdle : MArmed;
        m_pos[k] = 0; m_trig_pos[k] = 0; m_post[k] = 0; m_trig[k] = 0;
      end else if (m_mode[k] == MArmed && v) begin
        if (t) begin
          m_trig[k] = 1; m_trig_pos[k] = m_pos[k];
          if (ptc[k] > 0) begin m_pos[k]++; m_post[k] = 0; m_mode[k] = MPost; end
          else m_mode[k] = MDone;
        end else m_pos[k]++;
      end else if (m_mode[k] == MPost && v) begin
        m_post[k]++;
        if (m_post[k] == ptc[k]) m_mode[k] = MDone;
        else m_pos[k]++;
      end
    end
  endtask

  task automatic step(input bit r, input bit a, input bit v, input bit t);
    @(negedge clk);
    reset = r; arm = a; sample_valid = v; trigger = t;
    #1;
    we_pre[0] = bus3.write_enable; wa_pre[0] = bus3.waddr;
    we_pre[1] = bus0.write_enable; wa_pre[1] = bus0.waddr;
    for (int k = 0; k < 2; k++) begin
      exp_we_pre[k] = v && (m_mode[k] == MArmed || m_mode[k] == MPost);
      exp_wa_pre[k] = m_pos[k] % Depth;
    end
    @(posedge clk);
    model_update(r, a, v, t);
    #1;
    we_post[0] = bus3.write_enable; wa_o[0] = bus3.waddr; ta_o[0] = bus3.trigger_addr;
    tr_o[0] = bus3.triggered; wr_o[0] = bus3.wrapped; dn_o[0] = bus3.capture_done;
    we_post[1] = bus0.write_enable; wa_o[1] = bus0.waddr; ta_o[1] = bus0.trigger_addr;
    tr_o[1] = bus0.triggered; wr_o[1] = bus0.wrapped; dn_o[1] = bus0.capture_done;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 1'($urandom), 1, 1'($urandom));
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({we_post[k], wa_o[k], ta_o[k], tr_o[k], wr_o[k], dn_o[k]} !== 12'd0) begin
        errors++;
        $display("FAIL reset[%0d] got we=%b wa=%0d ta=%0d tr=%b wr=%b dn=%b want all 0", k,
                 we_post[k], wa_o[k], ta_o[k], tr_o[k], wr_o[k], dn_o[k]);
      end
    end
    step(0, 0, 1, 0);
    checks++;
    if (we_pre[0] !== 1'b0) begin
      errors++; $display("FAIL idle_no_write got %b want 0", we_pre[0]);
    end
  endtask

  task automatic test_basic();
    step(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, (i == 5));
      checks++;
      if (we_pre[0] !== 1'b1 || wa_pre[0] !== 4'(i)) begin
        errors++; $display("FAIL basic_write%0d got we=%b wa=%0d want we=1 wa=%0d",
                            i, we_pre[0], wa_pre[0], i);
      end
      if (i == 7) begin
        checks++;
        if (dn_o[0] !== 1'b0) begin
          errors++; $display("FAIL basic_early_done got %b want 0", dn_o[0]);
        end
      end
    end
    checks++;
    if (dn_o[0] !== 1'b1 || wa_o[0] !== 4'd8 || ta_o[0] !== 4'd5 || wr_o[0] !== 1'b0
        || tr_o[0] !== 1'b1) begin
      errors++; $display("FAIL basic_final got dn=%b wa=%0d ta=%0d wr=%b tr=%b want 1 8 5 0 1",
                          dn_o[0], wa_o[0], ta_o[0], wr_o[0], tr_o[0]);
    end
  endtask

  task automatic test_wrap();
    step(0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 1, 0);
      if (i == 15 || i == 16) begin
        checks++;
        if (wr_o[0] !== (i == 16)) begin
          errors++; $display("FAIL wrap_after_%0d got %b want %0d", i, wr_o[0], i == 16);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, (i == 0));
      checks++;
      if (wa_pre[0] !== 4'(4 + i)) begin
        errors++; $display("FAIL wrap_write%0d got %0d want %0d", i, wa_pre[0], 4 + i);
      end
    end
    checks++;
    if (dn_o[0] !== 1'b1 || wa_o[0] !== 4'd7 || ta_o[0] !== 4'd4 || wr_o[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_final got dn=%b wa=%0d ta=%0d wr=%b want 1 7 4 1",
                          dn_o[0], wa_o[0], ta_o[0], wr_o[0]);
    end
  endtask

  task automatic test_gaps();
    bit pat[6] = '{1, 0, 0, 1, 0, 1};
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    checks++;
    if (tr_o[0] !== 1'b0 || we_pre[0] !== 1'b0) begin
      errors++; $display("FAIL unqualified_trigger got tr=%b we=%b want 0 0", tr_o[0], we_pre[0]);
    end
    step(0, 0, 1, 1);
    for (int j = 0; j < 6; j++) begin
      step(0, 0, pat[j], 1);
      checks++;
      if (we_pre[0] !== pat[j] || dn_o[0] !== (j == 5)) begin
        errors++; $display("FAIL gaps_cycle%0d got we=%b dn=%b want we=%b dn=%0d",
                            j, we_pre[0], dn_o[0], pat[j], j == 5);
      end
    end
    checks++;
    if (wa_o[0] !== 4'd3 || ta_o[0] !== 4'd0) begin
      errors++; $display("FAIL gaps_final got wa=%0d ta=%0d want 3 0", wa_o[0], ta_o[0]);
    end
  endtask

  task automatic test_ptc0();
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    checks++;
    if (we_pre[1] !== 1'b1 || wa_pre[1] !== 4'd0 || dn_o[1] !== 1'b1 || wa_o[1] !== 4'd0
        || ta_o[1] !== 4'd0 || tr_o[1] !== 1'b1) begin
      errors++; $display("FAIL ptc0 got we=%b wpre=%0d dn=%b wa=%0d ta=%0d tr=%b want 1 0 1 0 0 1",
                          we_pre[1], wa_pre[1], dn_o[1], wa_o[1], ta_o[1], tr_o[1]);
    end
    step(0, 0, 1, 0);
    checks++;
    if (we_pre[1] !== 1'b0) begin
      errors++; $display("FAIL ptc0_frozen got we=%b want 0", we_pre[1]);
    end
  endtask

  task automatic test_reset_mid_post();
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(1, 1, 1, 1);
    checks++;
    if ({wa_o[0], ta_o[0], tr_o[0], wr_o[0], dn_o[0], we_post[0]} !== 12'd0) begin
      errors++; $display("FAIL reset_mid_post got wa=%0d ta=%0d tr=%b wr=%b dn=%b we=%b want 0",
                          wa_o[0], ta_o[0], tr_o[0], wr_o[0], dn_o[0], we_post[0]);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1'($urandom));
      checks++;
      if (we_pre[0] !== 1'b0 || wa_o[0] !== 4'd0) begin
        errors++; $display("FAIL post_reset_idle%0d got we=%b wa=%0d want 0 0", i, we_pre[0], wa_o[0]);
      end
    end
  endtask

  task automatic test_rearm();
    step(0, 1, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, (i == 0));
    step(0, 1, 0, 0);
    checks++;
    if (dn_o[0] !== 1'b0 || wa_o[0] !== 4'd0 || wr_o[0] !== 1'b0 || tr_o[0] !== 1'b0) begin
      errors++; $display("FAIL rearm got dn=%b wa=%0d wr=%b tr=%b want 0 0 0 0",
                          dn_o[0], wa_o[0], wr_o[0], tr_o[0]);
    end
    step(0, 0, 1, 0);
    checks++;
    if (we_pre[0] !== 1'b1 || wa_pre[0] !== 4'd0) begin
      errors++; $display("FAIL rearm_first_write got we=%b wa=%0d want 1 0", we_pre[0], wa_pre[0]);
    end
    step(0, 1, 1, 0);
    checks++;
    if (wa_pre[0] !== 4'd1 || wa_o[0] !== 4'd2) begin
      errors++; $display("FAIL arm_in_armed got pre=%0d post=%0d want 1 2", wa_pre[0], wa_o[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (we_pre[k] !== exp_we_pre[k] || wa_pre[k] !== 4'(exp_wa_pre[k])
            || wa_o[k] !== 4'(m_pos[k] % Depth) || ta_o[k] !== 4'(m_trig_pos[k] % Depth)
            || tr_o[k] !== m_trig[k] || wr_o[k] !== (m_pos[k] >= Depth)
            || dn_o[k] !== (m_mode[k] == MDone)) begin
          errors++;
          $display("FAIL random[%0d] cyc%0d got we=%b wpre=%0d wa=%0d ta=%0d tr=%b wr=%b dn=%b want %b %0d %0d %0d %b %0d %0d",
                   k, n, we_pre[k], wa_pre[k], wa_o[k], ta_o[k], tr_o[k], wr_o[k], dn_o[k],
                   exp_we_pre[k], exp_wa_pre[k] % Depth, m_pos[k] % Depth,
                   m_trig_pos[k] % Depth, m_trig[k], m_pos[k] >= Depth, m_mode[k] == MDone);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = MIdle; m_pos[k] = 0; m_trig_pos[k] = 0; m_post[k] = 0; m_trig[k] = 0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_ptc0();
    test_reset_mid_post();
    test_rearm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_address_controller.md
WRITE_ADDRESS_CONTROLLER -- requirements
Module: write_address_controller

Interface
REQ-001 Parameter ADDR_WIDTH, default `ADDR_WIDTH (define.v), sample buffer address width; buffer depth = 2^ADDR_WIDTH.
REQ-002 Parameter POST_TRIGGER_COUNT, default 8, samples written after the trigger sample; legal range 0..2^ADDR_WIDTH-1.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 arm  input  1  start or restart a capture.
REQ-006 sample_valid  input  1  a new sample is present this cycle.
REQ-007 trigger  input  1  trigger condition; qualified by sample_valid.
REQ-008 write_enable  output  1  buffer write strobe; the buffer writes its data at waddr when high.
REQ-009 waddr  output  ADDR_WIDTH  buffer write pointer, registered.
REQ-010 trigger_addr  output  ADDR_WIDTH  address of the trigger sample, registered.
REQ-011 triggered  output  1  trigger accepted in the current capture, registered.
REQ-012 wrapped  output  1  pointer has wrapped at least once in the current capture (buffer full of valid pre-trigger data), registered.
REQ-013 capture_done  output  1  capture complete and buffer frozen for readout, registered.

Function
REQ-014 The block SHALL implement states IDLE, ARMED, POST, DONE.
REQ-015 write_enable SHALL be combinational: sample_valid AND (state ARMED or POST); it SHALL be 0 in IDLE and DONE.
REQ-016 IDLE: arm=1 -> ARMED next edge; waddr, wrapped, triggered, trigger_addr and post counter cleared. trigger is ignored.
REQ-017 ARMED, write without trigger: waddr <= waddr+1 modulo 2^ADDR_WIDTH.
REQ-018 A waddr transition from 2^ADDR_WIDTH-1 to 0 SHALL set wrapped; wrapped is sticky until the next arm or reset.
REQ-019 ARMED, sample_valid=1 and trigger=1: the current sample is the trigger sample. It is written at waddr, and trigger_addr <= waddr. triggered <= 1.
REQ-020 After the trigger write with POST_TRIGGER_COUNT>0: waddr increments and the state goes to POST, post counter=0.
REQ-021 After the trigger write with POST_TRIGGER_COUNT=0: waddr holds and the state goes to DONE.
REQ-022 trigger without sample_valid SHALL be ignored.
REQ-023 POST: each write increments the post counter. On a write that is not the final one, waddr increments.
REQ-024 POST, final write: on the write that makes the counter equal POST_TRIGGER_COUNT, waddr SHALL hold (pointing at the last written sample) and the state goes to DONE.
REQ-025 POST: trigger is ignored, and wrapped continues to update per REQ-018.
REQ-026 DONE: capture_done=1; waddr, trigger_addr, wrapped and triggered are frozen. The oldest valid sample is at waddr+1 if wrapped, else at address 0.
REQ-027 DONE: arm=1 -> ARMED next edge; performs the REQ-016 clears and sets capture_done <= 0.
REQ-028 arm in ARMED or POST SHALL be ignored.
REQ-029 Post counter width SHALL be ADDR_WIDTH bits. Pointer arithmetic is modulo 2^ADDR_WIDTH with no overflow flag.
REQ-030 Latency: capture_done rises on the edge that completes the final post-trigger write.

Reset
REQ-031 reset=1 at a clock edge SHALL force: state IDLE, waddr=0, trigger_addr=0, triggered=0, wrapped=0, capture_done=0, post counter=0. write_enable is therefore 0.
REQ-032 reset SHALL take priority over arm, sample_valid and trigger, in every state including mid-POST.

Verification (ADDR_WIDTH=4, POST_TRIGGER_COUNT=3 unless stated)
REQ-033 Basic capture: arm, then 5 valid samples, then trigger on the 6th sample, then 3 valid samples -> writes at 0..8; trigger_addr=5; capture_done=1 after the write at 8; waddr=8; wrapped=0.
REQ-034 Wrap: arm, then 20 valid samples, then trigger on the 21st -> wrapped=1 from the edge of the 16th write; trigger_addr=4; writes at 5,6,7; done with waddr=7.
REQ-035 Gaps and qualification: during POST, sample_valid toggles 1,0,0,1,0,1 with trigger=1 throughout -> only 3 writes counted; done after the 6th cycle. trigger asserted with sample_valid=0 in ARMED -> no trigger accepted.
REQ-036 POST_TRIGGER_COUNT=0: trigger on the first sample -> write at 0; capture_done next edge; waddr=0; trigger_addr=0.
REQ-037 Reset mid-POST: reset after 1 post-trigger write -> all outputs at REQ-031 values next edge; later samples produce no write_enable until arm.
REQ-038 Rearm: arm in DONE -> capture_done=0 next edge; waddr=0; wrapped=0; the next sample writes at 0. arm pulsed in ARMED -> no effect on waddr.
